// File: rtl/bitloc_pkg.sv
// Shared constants and helpers for the bit-location engine scheduler.
package bitloc_pkg;
  localparam int N_REQ_DEF  = 4;
  localparam int DATA_WIDTH = 8;
  localparam int IDX_W      = $clog2(DATA_WIDTH);
  localparam int DEPTH_DEF  = 4;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

  // Round-robin successor with an explicit wrap so non-power-of-2 counts work.
  function automatic int rr_next(input int id, input int n);
    return (id == n - 1) ? 0 : id + 1;
  endfunction
endpackage

// File: rtl/bitloc_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding engine transaction.
module bitloc_tag_fifo
  import bitloc_pkg::*;
#(
  parameter type T       = req_id_t,
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  T            mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/bitloc_rr_scheduler.sv
// Round-robin sharing of one bit-location engine; results are routed back in issue order.
module bitloc_rr_scheduler
  import bitloc_pkg::rr_next;
#(
  parameter int N_REQ      = bitloc_pkg::N_REQ_DEF,
  parameter int DATA_WIDTH = bitloc_pkg::DATA_WIDTH,
  parameter int IDX_W      = $clog2(DATA_WIDTH),
  parameter int DEPTH      = bitloc_pkg::DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_rdy,
  output logic                        eng_vld,
  output logic [DATA_WIDTH-1:0]       eng_data,
  input  logic                        eng_rdy,
  input  logic                        eng_res_vld,
  input  logic [IDX_W-1:0]            eng_res_idx,
  output logic                        eng_res_rdy,
  output logic [N_REQ-1:0]            rsp_vld,
  output logic [IDX_W-1:0]            rsp_idx,
  input  logic [N_REQ-1:0]            rsp_rdy,
  output logic [$clog2(DEPTH+1)-1:0]  outstanding,
  output logic                        err_orphan
);
  localparam int ID_W = $clog2(N_REQ);
  typedef logic [ID_W-1:0] id_t;

  id_t  rr_ptr, lock_id, rr_win, winner, head;
  logic lock, full, empty, push, pop;

  // Scan from rr_ptr upward with explicit wrap.
  always_comb begin : arb
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    rr_win = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        rr_win = id_t'(idx);
      end
    end
  end

  assign winner   = lock ? lock_id : rr_win;
  assign eng_vld  = !rst && !full && (|req_vld);
  assign eng_data = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign push     = eng_vld && eng_rdy;

  always_comb begin
    req_rdy = '0;
    if (push) req_rdy[winner] = 1'b1;
  end

  // Empty FIFO swallows stray results so the engine never stalls on them.
  assign eng_res_rdy = !rst && (empty ? eng_res_vld : rsp_rdy[head]);
  assign pop         = eng_res_vld && eng_res_rdy && !empty;
  assign rsp_idx     = eng_res_idx;

  always_comb begin
    rsp_vld = '0;
    if (!rst && eng_res_vld && !empty) rsp_vld[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= id_t'(rr_next(int'(winner), N_REQ));
        lock   <= 1'b0;
      end else if (eng_vld) begin
        lock    <= 1'b1;
        lock_id <= winner;
      end
      if (eng_res_vld && empty) err_orphan <= 1'b1;
    end
  end

  bitloc_tag_fifo #(.T(id_t), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (winner),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );
endmodule

// File: tb/tb_bitloc_rr_scheduler.sv
// Directed bench: fairness table plus hand-written lock, routing, full and orphan sequences.
module tb_bitloc_rr_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        eng_vld;
  logic [7:0]  eng_data;
  logic        eng_rdy;
  logic        eng_res_vld;
  logic [2:0]  eng_res_idx;
  logic        eng_res_rdy;
  logic [3:0]  rsp_vld;
  logic [2:0]  rsp_idx;
  logic [3:0]  rsp_rdy;
  logic [2:0]  outstanding;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitloc_rr_scheduler #(.N_REQ(4), .DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .eng_vld(eng_vld), .eng_data(eng_data), .eng_rdy(eng_rdy),
    .eng_res_vld(eng_res_vld), .eng_res_idx(eng_res_idx), .eng_res_rdy(eng_res_rdy),
    .rsp_vld(rsp_vld), .rsp_idx(rsp_idx), .rsp_rdy(rsp_rdy),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [3:0] vld;
    logic       res_vld;
    logic [2:0] res_idx;
    logic [3:0] x_rdy;
    logic       x_eng_vld;
    logic [7:0] x_data;
    logic [3:0] x_rsp;
    logic [2:0] x_out;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic r, input logic rv,
                       input logic [2:0] ri, input logic [3:0] rr);
    req_vld     = v;
    eng_rdy     = r;
    eng_res_vld = rv;
    eng_res_idx = ri;
    rsp_rdy     = rr;
  endtask

  // Outputs are checked 1ns after a negedge; the next posedge comes after nxt.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
    nxt(); nxt();
    rst = 1'b0;
  endtask

  initial begin
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);

    // Fairness vectors: engine returns one result per cycle from row 1 on.
    tbl[0] = '{4'hF, 1'b0, 3'd0, 4'b0001, 1'b1, 8'h11, 4'b0000, 3'd0};
    tbl[1] = '{4'hF, 1'b1, 3'd5, 4'b0010, 1'b1, 8'h22, 4'b0001, 3'd1};
    tbl[2] = '{4'hF, 1'b1, 3'd1, 4'b0100, 1'b1, 8'h33, 4'b0010, 3'd1};
    tbl[3] = '{4'hF, 1'b1, 3'd7, 4'b1000, 1'b1, 8'h44, 4'b0100, 3'd1};
    tbl[4] = '{4'hF, 1'b1, 3'd2, 4'b0001, 1'b1, 8'h11, 4'b1000, 3'd1};
    tbl[5] = '{4'hF, 1'b1, 3'd6, 4'b0010, 1'b1, 8'h22, 4'b0001, 3'd1};
    tbl[6] = '{4'hF, 1'b1, 3'd3, 4'b0100, 1'b1, 8'h33, 4'b0010, 3'd1};
    tbl[7] = '{4'hF, 1'b1, 3'd4, 4'b1000, 1'b1, 8'h44, 4'b0100, 3'd1};
    tbl[8] = '{4'h0, 1'b1, 3'd0, 4'b0000, 1'b0, 8'h11, 4'b1000, 3'd1};

    // 1: reset held with every requester valid
    nxt(); nxt(); #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'h0);
    chk("rst_eng_vld", 32'(eng_vld), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_err_orphan", 32'(err_orphan), 32'h0);
    nxt();
    do_reset();

    // 2: fairness table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vld, 1'b1, tbl[i].res_vld, tbl[i].res_idx, 4'b1111);
      #1;
      chk($sformatf("fair%0d_req_rdy", i), 32'(req_rdy), 32'(tbl[i].x_rdy));
      chk($sformatf("fair%0d_eng_vld", i), 32'(eng_vld), 32'(tbl[i].x_eng_vld));
      if (tbl[i].x_eng_vld) chk($sformatf("fair%0d_eng_data", i), 32'(eng_data), 32'(tbl[i].x_data));
      chk($sformatf("fair%0d_rsp_vld", i), 32'(rsp_vld), 32'(tbl[i].x_rsp));
      if (tbl[i].res_vld) chk($sformatf("fair%0d_rsp_idx", i), 32'(rsp_idx), 32'(tbl[i].res_idx));
      chk($sformatf("fair%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].x_out));
      nxt();
    end
    drive(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1;
    chk("fair_drained", 32'(outstanding), 32'h0);
    chk("fair_no_orphan", 32'(err_orphan), 32'h0);
    nxt();

    // 3: lock on requester 2 while requester 0 also waits
    do_reset();
    drive(4'b0010, 1'b1, 1'b0, 3'd0, 4'b1111);
    nxt();
    req_data = {8'h44, 8'h10, 8'h22, 8'hAA};
    for (int c = 0; c < 3; c++) begin
      drive(4'b0101, 1'b0, 1'b0, 3'd0, 4'b1111);
      #1;
      chk($sformatf("lock%0d_eng_data", c), 32'(eng_data), 32'h10);
      chk($sformatf("lock%0d_eng_vld", c), 32'(eng_vld), 32'h1);
      chk($sformatf("lock%0d_req_rdy", c), 32'(req_rdy), 32'h0);
      nxt();
    end
    drive(4'b0101, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1;
    chk("lock_accept_req_rdy", 32'(req_rdy), 32'b0100);
    chk("lock_accept_data", 32'(eng_data), 32'h10);
    nxt();
    drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b1111);
    #1;
    chk("lock_rr_ptr3_data", 32'(eng_data), 32'h44);
    chk("lock_outstanding", 32'(outstanding), 32'd2);
    nxt();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};

    // 4: routing of two results back to requesters 1 and 3
    do_reset();
    drive(4'b0010, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1 chk("route_issue1", 32'(req_rdy), 32'b0010);
    nxt();
    drive(4'b1000, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1 chk("route_issue3", 32'(req_rdy), 32'b1000);
    nxt();
    drive(4'b0000, 1'b1, 1'b1, 3'd4, 4'b1111);
    #1;
    chk("route_out2", 32'(outstanding), 32'd2);
    chk("route_rsp1_vld", 32'(rsp_vld), 32'b0010);
    chk("route_rsp1_idx", 32'(rsp_idx), 32'd4);
    chk("route_rsp1_rdy", 32'(eng_res_rdy), 32'h1);
    nxt();
    drive(4'b0000, 1'b1, 1'b1, 3'd0, 4'b1111);
    #1;
    chk("route_rsp2_vld", 32'(rsp_vld), 32'b1000);
    chk("route_rsp2_idx", 32'(rsp_idx), 32'd0);
    nxt();
    drive(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1;
    chk("route_out0", 32'(outstanding), 32'd0);
    chk("route_no_orphan", 32'(err_orphan), 32'h0);
    nxt();

    // 5: fill the FIFO, then backpressure and a single pop
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);
      #1 chk($sformatf("full_issue%0d", c), 32'(req_rdy), 32'(4'b0001 << c));
      nxt();
    end
    drive(4'b1111, 1'b1, 1'b1, 3'd2, 4'b0000);
    #1;
    chk("full_outstanding4", 32'(outstanding), 32'd4);
    chk("full_eng_vld", 32'(eng_vld), 32'h0);
    chk("full_req_rdy", 32'(req_rdy), 32'h0);
    chk("full_bp_res_rdy", 32'(eng_res_rdy), 32'h0);
    chk("full_bp_rsp_vld", 32'(rsp_vld), 32'b0001);
    nxt();
    drive(4'b1111, 1'b1, 1'b1, 3'd2, 4'b0001);
    #1;
    chk("full_hold4", 32'(outstanding), 32'd4);
    chk("full_pop_res_rdy", 32'(eng_res_rdy), 32'h1);
    chk("full_pop_eng_vld", 32'(eng_vld), 32'h0);
    nxt();
    drive(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);
    #1;
    chk("full_after_pop_out", 32'(outstanding), 32'd3);
    chk("full_resume_eng_vld", 32'(eng_vld), 32'h1);
    chk("full_resume_req_rdy", 32'(req_rdy), 32'b0001);
    chk("full_resume_data", 32'(eng_data), 32'h11);
    nxt();

    // 6: orphan result with nothing outstanding
    do_reset();
    drive(4'b0000, 1'b1, 1'b1, 3'd5, 4'b1111);
    #1;
    chk("orphan_res_rdy", 32'(eng_res_rdy), 32'h1);
    chk("orphan_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("orphan_pre", 32'(err_orphan), 32'h0);
    nxt();
    drive(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
    nxt(); nxt();
    #1;
    chk("orphan_sticky", 32'(err_orphan), 32'h1);
    chk("orphan_outstanding", 32'(outstanding), 32'h0);
    nxt();
    do_reset();
    #1 chk("orphan_cleared", 32'(err_orphan), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
